// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side controller.
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Valid/ready output stream of the burst reader.
interface fifo_burst_reader_if #(
  parameter int WIDTH = fifo_pkg::DEF_FIFO_WIDTH
) ();

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer between the FIFO read data and the output stream.
module fifo_rd_skid #(
  parameter int WIDTH = fifo_pkg::DEF_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (capture) begin
        mem[wr_ptr] <= cap_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({capture, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side FIFO controller: drains a programmed word count onto a valid/ready
// stream through a 2-entry buffer so backpressure never causes over-reads.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter  int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter  int MAX_BURST  = 256,
  localparam int LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  fifo_burst_reader_if.master   m_stream,
  output logic                  underflow_err,
  output logic [LEN_W-1:0]      words_out
);

  rd_state_t        state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] len_sat;
  logic             inflight;
  logic [1:0]       occ;
  logic [FIFO_WIDTH-1:0] head;
  logic             pop;
  logic             last_pop;
  logic [2:0]       eff_occ;

  fifo_rd_skid #(.WIDTH(FIFO_WIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .capture  (inflight),
    .cap_data (data_out),
    .pop      (pop),
    .occ      (occ),
    .head     (head)
  );

  assign m_stream.m_valid = (occ != 2'd0);
  assign m_stream.m_data  = head;
  assign pop      = m_stream.m_valid && m_stream.m_ready;
  assign last_pop = pop && ((words_out + LEN_W'(1)) == len_q);
  assign len_sat  = (burst_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : burst_len;

  // Occupancy is credited with this cycle's pop so a draining consumer keeps
  // rd_en asserted every cycle instead of every other cycle.
  assign eff_occ = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    rd_en = (state == READ) && !empty && (remaining != '0) && (eff_occ < 3'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len_q         <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      words_out     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      inflight <= rd_en;
      done     <= 1'b0;
      if (pop) words_out <= words_out + LEN_W'(1);
      if (busy && underflow) underflow_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            len_q         <= len_sat;
            remaining     <= len_sat;
            words_out     <= '0;
            underflow_err <= 1'b0;
            busy          <= 1'b1;
            if (len_sat == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (rd_en) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overfill: assert property (@(posedge clk) disable iff (rst)
    !(inflight && (occ == 2'd2) && !pop));
  a_read_ahead: assert property (@(posedge clk) disable iff (rst)
    (int'(occ) + int'(inflight)) <= FIFO_DEPTH);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized self-checking bench for fifo_burst_reader with a queue-based FIFO
// and a transaction-level expectation of each burst.
module tb_fifo_burst_reader;

  localparam int MAX_B = 12;
  localparam int LEN_W = $clog2(MAX_B + 1);
  localparam int W     = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             busy, done, rd_en, underflow_err;
  logic [W-1:0]     data_out = '0;
  logic             empty = 1'b1;
  logic             underflow = 1'b0;
  logic [LEN_W-1:0] words_out;

  fifo_burst_reader_if #(.WIDTH(W)) s_if ();

  fifo_burst_reader #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (8),
    .MAX_BURST  (MAX_B)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .burst_len     (burst_len),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .data_out      (data_out),
    .empty         (empty),
    .underflow     (underflow),
    .m_stream      (s_if.master),
    .underflow_err (underflow_err),
    .words_out     (words_out)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fq[$];
  logic [W-1:0] refill_q[$];
  logic [W-1:0] exp_q[$];
  int rd_cycles[$];
  int hs_cycles[$];
  int cyc = 0, refill_at = -1, start_cyc = 0;
  int rd_cnt = 0, hs_cnt = 0, done_cnt = 0, done_cyc = -1, last_hs = -1;
  logic [W-1:0]     dout_next = '0;
  logic             uf_next = 1'b0, uf_force = 1'b0, start_now = 1'b0, ready_v = 1'b0;
  logic [LEN_W-1:0] len_in = '0;
  int n_cmp = 0, n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic pick(input int mode, input int k, input int stall);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return (k >= stall);
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 ns later, then
  // apply the FIFO's response to what the DUT requested for the coming edge.
  task automatic step();
    logic hs;
    @(negedge clk);
    cyc++;
    if (cyc == refill_at) begin
      while (refill_q.size() > 0) fq.push_back(refill_q.pop_front());
    end
    data_out      = dout_next;
    underflow     = uf_next | uf_force;
    empty         = (fq.size() == 0);
    start         = start_now;
    burst_len     = len_in;
    s_if.m_ready  = ready_v;
    #1;
    hs = s_if.m_valid && s_if.m_ready;
    if (busy) check("words_out_live", 32'(words_out), hs_cnt);
    if (hs) begin
      if (exp_q.size() > 0) check("data", 32'(s_if.m_data), 32'(exp_q.pop_front()));
      else check("excess_word", 32'(hs), 0);
      hs_cnt++;
      hs_cycles.push_back(cyc);
      last_hs = cyc;
    end
    if (rd_en) begin
      rd_cnt++;
      rd_cycles.push_back(cyc);
      check("rd_while_empty", 32'(empty), 0);
      check("read_ahead", 32'((rd_cnt - hs_cnt) <= 2), 1);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    uf_next = rd_en && empty;
    if (rd_en && fq.size() > 0) dout_next = fq.pop_front();
    start_now = 1'b0;
  endtask

  task automatic run_burst(input int len, input int mode, input int stall,
                           input int pre_n, input int late_n, input int late_dly,
                           input int restart_off, input int uf_off);
    int   lsat, avail, guard, k;
    logic seen_done;
    lsat = (len > MAX_B) ? MAX_B : len;
    for (int i = 0; i < pre_n; i++) fq.push_back(W'($urandom));
    refill_q.delete();
    for (int i = 0; i < late_n; i++) refill_q.push_back(W'($urandom));
    exp_q.delete();
    foreach (fq[i])       if (exp_q.size() < lsat) exp_q.push_back(fq[i]);
    foreach (refill_q[i]) if (exp_q.size() < lsat) exp_q.push_back(refill_q[i]);
    avail = fq.size() + refill_q.size();
    rd_cnt = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
    rd_cycles.delete(); hs_cycles.delete();
    start_cyc = cyc + 1;
    refill_at = (late_n > 0) ? start_cyc + late_dly : -1;
    start_now = 1'b1;
    len_in    = LEN_W'(len);
    ready_v   = pick(mode, 0, stall);
    step();
    guard = 0;
    seen_done = 1'b0;
    while (!seen_done && guard < 300) begin
      k = cyc + 1 - start_cyc;
      ready_v = pick(mode, k, stall);
      if (k == restart_off) begin
        start_now = 1'b1;
        len_in    = LEN_W'($urandom_range(0, 15));
      end
      uf_force = (k == uf_off);
      step();
      if (k == 1) begin
        check("busy_rise", 32'(busy), 1);
        check("uf_err_cleared", 32'(underflow_err), 0);
      end
      seen_done = done;
      guard++;
    end
    uf_force = 1'b0;
    if (!seen_done) check("done_timeout", 32'(seen_done), 1);
    ready_v = 1'b1;
    step();
    check("busy_fall", 32'(busy), 0);
    check("done_single", 32'(done), 0);
    check("rd_count", rd_cnt, lsat);
    check("hs_count", hs_cnt, lsat);
    check("words_out_final", 32'(words_out), lsat);
    check("done_count", done_cnt, 1);
    check("done_time", done_cyc, (lsat == 0) ? start_cyc + 1 : last_hs + 1);
    check("uf_err_final", 32'(underflow_err), 32'(uf_off != 0));
    while (refill_q.size() > 0) fq.push_back(refill_q.pop_front());
    refill_at = -1;
    check("no_overread", fq.size(), avail - lsat);
  endtask

  initial begin
    s_if.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_m_valid", 32'(s_if.m_valid), 0);
    check("rst_m_data", 32'(s_if.m_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_uf_err", 32'(underflow_err), 0);
    check("rst_words_out", 32'(words_out), 0);

    // Full-rate burst of four preloaded words.
    fq.delete();
    for (int i = 0; i < 4; i++) fq.push_back(W'(16'h00A1 + i));
    run_burst(4, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (rd_cycles.size() > i) check("t1_rd_cycle", rd_cycles[i], start_cyc + 1 + i);
      if (hs_cycles.size() > i) check("t1_hs_cycle", hs_cycles[i], start_cyc + 3 + i);
    end

    // Ten cycles of backpressure: only two words may be read ahead.
    fq.delete();
    run_burst(6, 2, 10, 6, 0, 0, 0, 0);
    begin
      int n = 0;
      foreach (rd_cycles[i]) if (rd_cycles[i] < start_cyc + 10) n++;
      check("t2_stall_reads", n, 2);
    end

    // FIFO runs dry after two words and refills five cycles later.
    fq.delete();
    run_burst(5, 0, 0, 2, 3, 8, 0, 0);
    begin
      int n = 0;
      foreach (rd_cycles[i]) if (rd_cycles[i] > start_cyc + 2 && rd_cycles[i] < start_cyc + 8) n++;
      check("t3_reads_while_empty", n, 0);
      if (rd_cycles.size() > 2) check("t3_resume_cycle", rd_cycles[2], start_cyc + 8);
    end

    // Zero-length burst.
    run_burst(0, 0, 0, 0, 0, 0, 0, 0);

    // Over-length request saturates.
    fq.delete();
    run_burst(15, 1, 0, 14, 0, 0, 0, 0);

    // Reset with two words buffered.
    fq.delete();
    for (int i = 0; i < 6; i++) fq.push_back(W'(16'h00C0 + i));
    exp_q.delete();
    rd_cnt = 0; hs_cnt = 0; rd_cycles.delete(); hs_cycles.delete();
    start_now = 1'b1; len_in = LEN_W'(6); ready_v = 1'b0;
    step();
    repeat (5) step();
    check("pre_rst_valid", 32'(s_if.m_valid), 1);
    check("pre_rst_reads", rd_cnt, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", 32'(s_if.m_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_en", 32'(rd_en), 0);
    @(negedge clk);
    rst = 1'b0;
    dout_next = '0;
    uf_next = 1'b0;
    check("rst_fifo_left", fq.size(), 4);
    run_burst(2, 0, 0, 0, 0, 0, 0, 0);

    // Underflow flag while busy is sticky past done and cleared by start.
    fq.delete();
    run_burst(3, 0, 0, 3, 0, 0, 0, 2);
    run_burst(2, 0, 0, 2, 0, 0, 0, 0);

    for (int it = 0; it < 25; it++) begin
      int len, lsat, pre, late, roff, uoff;
      len  = $urandom_range(0, 15);
      lsat = (len > MAX_B) ? MAX_B : len;
      pre  = $urandom_range(0, lsat);
      late = lsat - pre + $urandom_range(0, 2);
      roff = ($urandom_range(0, 1) == 1) ? $urandom_range(2, lsat + 2) : 0;
      uoff = (lsat > 0 && $urandom_range(0, 3) == 0) ? 2 : 0;
      run_burst(len, $urandom_range(0, 2), $urandom_range(0, 8), pre, late,
                $urandom_range(1, 12), roff, uoff);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
